// File: rtl/cw310_usb_reg_responder.sv
// rtl/cw310_usb_reg_responder.sv - SAM3U parallel USB bus responder producing reg_read/reg_write strobes
module cw310_usb_reg_responder #(
    parameter int pADDR_WIDTH   = 20,
    parameter int pBYTECNT_SIZE = 7,
    parameter int pREAD_LATENCY = 1
) (
    input  logic                                 usb_clk,
    input  logic                                 reset,
    input  logic [7:0]                           usb_din,
    output logic [7:0]                           usb_dout,
    output logic                                 usb_isout,
    input  logic [pADDR_WIDTH-1:0]               usb_addr,
    input  logic                                 usb_rdn,
    input  logic                                 usb_wrn,
    input  logic                                 usb_cen,
    output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
    output logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
    output logic [7:0]                           reg_datao,
    input  logic [7:0]                           reg_datai,
    output logic                                 reg_read,
    output logic                                 reg_write,
    output logic                                 reg_addrvalid,
    output logic                                 proto_err,
    output logic [7:0]                           proto_err_cnt
);

    localparam logic [1:0] LAT = 2'(pREAD_LATENCY);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WSTROBE = 3'd1,
        RWAIT   = 3'd2,
        RDRIVE  = 3'd3,
        RHOLD   = 3'd4
    } state_t;

    state_t                   state;
    logic [pADDR_WIDTH-1:0]   addr_s1;
    logic [7:0]               din_s1;
    logic                     rdn_s1, rdn_s2;
    logic                     wrn_s1, wrn_s2;
    logic                     cen_s1, cen_s2;
    logic [1:0]               lat_cnt;
    logic                     rd_abort;

    logic coll_s1, coll_s2, wr_start, rd_start;

    assign coll_s1  = ~rdn_s1 & ~wrn_s1 & ~cen_s1;
    assign coll_s2  = ~rdn_s2 & ~wrn_s2 & ~cen_s2;
    assign wr_start = ~cen_s1 & ~wrn_s1 & wrn_s2 & rdn_s1;
    assign rd_start = ~cen_s1 & ~rdn_s1 & rdn_s2 & wrn_s1;

    assign reg_addrvalid = ~cen_s1;

    always_ff @(posedge usb_clk) begin
        if (reset) begin
            state         <= IDLE;
            addr_s1       <= '0;
            din_s1        <= '0;
            rdn_s1        <= 1'b1;
            rdn_s2        <= 1'b1;
            wrn_s1        <= 1'b1;
            wrn_s2        <= 1'b1;
            cen_s1        <= 1'b1;
            cen_s2        <= 1'b1;
            lat_cnt       <= '0;
            rd_abort      <= 1'b0;
            usb_dout      <= '0;
            usb_isout     <= 1'b0;
            reg_address   <= '0;
            reg_bytecnt   <= '0;
            reg_datao     <= '0;
            reg_read      <= 1'b0;
            reg_write     <= 1'b0;
            proto_err     <= 1'b0;
            proto_err_cnt <= '0;
        end else begin
            addr_s1   <= usb_addr;
            din_s1    <= usb_din;
            rdn_s1    <= usb_rdn;
            rdn_s2    <= rdn_s1;
            wrn_s1    <= usb_wrn;
            wrn_s2    <= wrn_s1;
            cen_s1    <= usb_cen;
            cen_s2    <= cen_s1;
            reg_read  <= 1'b0;
            reg_write <= 1'b0;

            case (state)
                IDLE: begin
                    usb_isout <= 1'b0;
                    if (coll_s1) begin
                        proto_err <= 1'b1;
                        if (!coll_s2 && proto_err_cnt != 8'hFF)
                            proto_err_cnt <= proto_err_cnt + 8'd1;
                    end else if (wr_start) begin
                        reg_address <= addr_s1[pADDR_WIDTH-1:pBYTECNT_SIZE];
                        reg_bytecnt <= addr_s1[pBYTECNT_SIZE-1:0];
                        reg_datao   <= din_s1;
                        reg_write   <= 1'b1;
                        state       <= WSTROBE;
                    end else if (rd_start) begin
                        reg_address <= addr_s1[pADDR_WIDTH-1:pBYTECNT_SIZE];
                        reg_bytecnt <= addr_s1[pBYTECNT_SIZE-1:0];
                        reg_read    <= 1'b1;
                        lat_cnt     <= '0;
                        rd_abort    <= 1'b0;
                        state       <= RWAIT;
                    end
                end
                WSTROBE: state <= IDLE;
                RWAIT: begin
                    // A deselect at any point of the wait means the host gave up on this byte.
                    if (cen_s1)
                        rd_abort <= 1'b1;
                    if (lat_cnt == LAT) begin
                        usb_dout <= reg_datai;
                        if (rd_abort || cen_s1) begin
                            state <= IDLE;
                        end else begin
                            usb_isout <= 1'b1;
                            state     <= RDRIVE;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                RDRIVE: begin
                    if (rdn_s1 || cen_s1)
                        state <= RHOLD;
                end
                RHOLD: begin
                    usb_isout <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    usb_isout <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cw310_usb_reg_responder.sv
// tb/tb_cw310_usb_reg_responder.sv - directed self-checking bench for cw310_usb_reg_responder
module tb_cw310_usb_reg_responder;

    logic        usb_clk = 1'b0;
    logic        reset   = 1'b1;
    logic [7:0]  usb_din = 8'h00;
    logic [7:0]  usb_dout;
    logic        usb_isout;
    logic [19:0] usb_addr = 20'h0;
    logic        usb_rdn = 1'b1;
    logic        usb_wrn = 1'b1;
    logic        usb_cen = 1'b1;
    logic [12:0] reg_address;
    logic [6:0]  reg_bytecnt;
    logic [7:0]  reg_datao;
    logic [7:0]  reg_datai;
    logic        reg_read;
    logic        reg_write;
    logic        reg_addrvalid;
    logic        proto_err;
    logic [7:0]  proto_err_cnt;

    int errors = 0;
    int checks = 0;

    cw310_usb_reg_responder #(
        .pADDR_WIDTH(20),
        .pBYTECNT_SIZE(7),
        .pREAD_LATENCY(1)
    ) dut (
        .usb_clk(usb_clk),
        .reset(reset),
        .usb_din(usb_din),
        .usb_dout(usb_dout),
        .usb_isout(usb_isout),
        .usb_addr(usb_addr),
        .usb_rdn(usb_rdn),
        .usb_wrn(usb_wrn),
        .usb_cen(usb_cen),
        .reg_address(reg_address),
        .reg_bytecnt(reg_bytecnt),
        .reg_datao(reg_datao),
        .reg_datai(reg_datai),
        .reg_read(reg_read),
        .reg_write(reg_write),
        .reg_addrvalid(reg_addrvalid),
        .proto_err(proto_err),
        .proto_err_cnt(proto_err_cnt)
    );

    always #5 usb_clk = ~usb_clk;

    // Register file model: one-cycle read latency, byte-indexed storage.
    logic [7:0] mem [0:15];
    logic [7:0] rdata = 8'h00;
    int         wr_count = 0;
    int         rd_count = 0;
    assign reg_datai = rdata;

    always @(posedge usb_clk) begin
        if (reg_write) begin
            mem[reg_bytecnt[3:0]] <= reg_datao;
            wr_count <= wr_count + 1;
        end
        if (reg_read) begin
            rdata    <= mem[reg_bytecnt[3:0]];
            rd_count <= rd_count + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge usb_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [12:0] r, input logic [6:0] bc, input logic [7:0] d);
        usb_addr = {r, bc};
        usb_din  = d;
        usb_cen  = 1'b0;
        tick(1);
        usb_wrn = 1'b0;
        tick(4);
        usb_wrn = 1'b1;
        tick(1);
        usb_cen = 1'b1;
        tick(3);
    endtask

    task automatic do_read(input logic [12:0] r, input logic [6:0] bc,
                           output logic [7:0] d, output logic drv);
        usb_addr = {r, bc};
        usb_cen  = 1'b0;
        tick(1);
        usb_rdn = 1'b0;
        tick(6);
        d   = usb_dout;
        drv = usb_isout;
        usb_rdn = 1'b1;
        tick(1);
        usb_cen = 1'b1;
        tick(4);
    endtask

    task automatic do_collide();
        usb_cen = 1'b0;
        tick(1);
        usb_rdn = 1'b0;
        usb_wrn = 1'b0;
        tick(3);
        usb_rdn = 1'b1;
        usb_wrn = 1'b1;
        tick(1);
        usb_cen = 1'b1;
        tick(2);
    endtask

    initial begin
        int         w0, r0;
        logic [7:0] d;
        logic       drv;
        logic       seen;

        tick(3);
        reset = 1'b0;
        tick(1);
        chk("rst_isout", usb_isout, 0);
        chk("rst_dout", usb_dout, 0);
        chk("rst_strobes", {reg_read, reg_write}, 0);
        chk("rst_addrvalid", reg_addrvalid, 0);
        chk("rst_proto", {proto_err, proto_err_cnt}, 0);
        chk("rst_addr", {reg_address, reg_bytecnt, reg_datao}, 0);

        // 1: single write, strobe timing and latched fields
        usb_addr = {13'd5, 7'd2};
        usb_din  = 8'hA5;
        usb_cen  = 1'b0;
        tick(1);
        chk("addrvalid", reg_addrvalid, 1);
        usb_wrn = 1'b0;
        w0 = wr_count;
        tick(1);
        chk("wr_edge1", reg_write, 0);
        tick(1);
        chk("wr_edge2", reg_write, 1);
        chk("wr_address", reg_address, 5);
        chk("wr_bytecnt", reg_bytecnt, 2);
        chk("wr_datao", reg_datao, 8'hA5);
        tick(1);
        chk("wr_edge3", reg_write, 0);
        tick(1);
        usb_wrn = 1'b1;
        tick(1);
        usb_cen = 1'b1;
        tick(3);
        chk("wr_single", wr_count - w0, 1);

        // 2: read of 0x3C with bus drive/release timing
        do_write(13'd5, 7'd3, 8'h3C);
        usb_addr = {13'd5, 7'd3};
        usb_cen  = 1'b0;
        tick(1);
        usb_rdn = 1'b0;
        r0 = rd_count;
        tick(1);
        chk("rd_edge1_isout", usb_isout, 0);
        tick(1);
        chk("rd_strobe", reg_read, 1);
        chk("rd_bytecnt", reg_bytecnt, 3);
        tick(1);
        chk("rd_strobe_end", reg_read, 0);
        tick(1);
        chk("rd_isout_on", usb_isout, 1);
        chk("rd_dout", usb_dout, 8'h3C);
        tick(2);
        chk("rd_isout_hold", usb_isout, 1);
        usb_rdn = 1'b1;
        tick(1);
        chk("rd_rise_s1", usb_isout, 1);
        tick(1);
        chk("rd_rhold", usb_isout, 1);
        tick(1);
        chk("rd_release", usb_isout, 0);
        usb_cen = 1'b1;
        tick(3);
        chk("rd_single", rd_count - r0, 1);

        // 3: 16-byte burst write then read back
        w0 = wr_count;
        r0 = rd_count;
        for (int i = 0; i < 16; i++)
            do_write(13'd5, 7'(i), 8'(i * 17) ^ 8'h5A);
        for (int i = 0; i < 16; i++) begin
            do_read(13'd5, 7'(i), d, drv);
            chk("burst_data", d, 8'(i * 17) ^ 8'h5A);
            chk("burst_drive", drv, 1);
        end
        chk("burst_wr_cnt", wr_count - w0, 16);
        chk("burst_rd_cnt", rd_count - r0, 16);

        // 4: collisions, sticky flag and saturating count
        w0 = wr_count;
        r0 = rd_count;
        chk("proto_clear", proto_err, 0);
        for (int i = 0; i < 3; i++)
            do_collide();
        chk("coll_no_strobe", (wr_count - w0) + (rd_count - r0), 0);
        chk("coll_err", proto_err, 1);
        chk("coll_cnt3", proto_err_cnt, 3);
        for (int i = 0; i < 260; i++)
            do_collide();
        chk("coll_cnt_sat", proto_err_cnt, 255);

        // 5: strobes without chip select, and deselect during the read wait
        w0 = wr_count;
        r0 = rd_count;
        usb_addr = {13'd5, 7'd0};
        usb_wrn = 1'b0;
        tick(4);
        usb_wrn = 1'b1;
        tick(4);
        usb_rdn = 1'b0;
        tick(4);
        usb_rdn = 1'b1;
        tick(4);
        chk("nocs_no_strobe", (wr_count - w0) + (rd_count - r0), 0);
        usb_cen = 1'b0;
        tick(1);
        usb_rdn = 1'b0;
        tick(2);
        chk("abort_strobe", reg_read, 1);
        usb_cen = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            seen = seen | usb_isout;
        end
        usb_rdn = 1'b1;
        tick(3);
        chk("abort_no_drive", seen, 0);
        chk("abort_read_done", rd_count - r0, 1);

        // 6: reset while driving the bus
        usb_addr = {13'd5, 7'd1};
        usb_cen  = 1'b0;
        tick(1);
        usb_rdn = 1'b0;
        tick(5);
        chk("pre_reset_drive", usb_isout, 1);
        reset = 1'b1;
        tick(1);
        chk("reset_isout", usb_isout, 0);
        chk("reset_outputs", {usb_dout, reg_address, reg_bytecnt, reg_datao,
                              reg_read, reg_write, reg_addrvalid, proto_err, proto_err_cnt}, 0);
        usb_rdn = 1'b1;
        usb_cen = 1'b1;
        tick(1);
        reset = 1'b0;
        w0 = wr_count;
        r0 = rd_count;
        tick(6);
        chk("post_reset_quiet", (wr_count - w0) + (rd_count - r0), 0);
        do_write(13'd9, 7'd7, 8'h99);
        chk("post_reset_addr", reg_address, 9);
        do_read(13'd9, 7'd7, d, drv);
        chk("post_reset_read", d, 8'h99);
        chk("post_reset_drive", drv, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
